// File: rtl/adc_scan_sequencer_pkg.sv
// adc_scan_sequencer_pkg: state encoding, OutData word layout and defaults shared by the scan sequencer
package adc_scan_sequencer_pkg;

    typedef enum logic [2:0] {IDLE, SELECT, SETTLE, ACQ, DRAIN, NEXT, DONE} scan_state_t;

    localparam int DRAIN_CYC_DEF = 8;

    // OutData = {first, ch[1:0], otr, data[11:0]}
    localparam int FIRST_BIT = 15;
    localparam int CH_LSB    = 13;
    localparam int OTR_BIT   = 12;
    localparam int DATA_W    = 12;

    function automatic logic [15:0] pack_word(input logic first, input logic [1:0] ch,
                                              input logic otr, input logic [DATA_W-1:0] data);
        logic [15:0] w;
        w                 = '0;
        w[FIRST_BIT]      = first;
        w[CH_LSB +: 2]    = ch;
        w[OTR_BIT]        = otr;
        w[DATA_W-1:0]     = data;
        return w;
    endfunction

endpackage

// File: rtl/adc_next_channel.sv
// adc_next_channel: finds the lowest enabled channel at or above (or strictly above) the current one
module adc_next_channel #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [1:0]        current,
    input  logic              include_current,
    output logic              found,
    output logic [1:0]        next_ch
);

    // scan downward so the lowest qualifying channel is the last one written
    always_comb begin
        found   = 1'b0;
        next_ch = 2'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(current) || (include_current && i == int'(current)))) begin
                found   = 1'b1;
                next_ch = 2'(i);
            end
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: steps the AD9220 acquisition path across enabled mux channels and tags each sample
module adc_scan_sequencer
    import adc_scan_sequencer_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic              ScanStart,
    input  logic              ScanAbort,
    input  logic [NUM_CH-1:0] ChannelMask,
    input  logic [7:0]        SettleCycles,
    input  logic [7:0]        SamplesPerCh,
    input  logic              AdcData_en,
    input  logic [11:0]       AdcData,
    input  logic              ADC_OTR,
    input  logic              FifoFull,
    output logic [1:0]        MuxSel,
    output logic              AdcStart,
    output logic [15:0]       OutData,
    output logic              OutData_en,
    output logic              ScanBusy,
    output logic              ScanDone,
    output logic              OverflowErr
);

    scan_state_t       state;
    logic [NUM_CH-1:0] mask_q;
    logic [7:0]        settle_q, samples_q, tmr, cnt;
    logic [1:0]        cur_ch, nxt_ch;
    logic              nxt_found, settle_end, drain_end, last_sample;

    // in IDLE search the live mask from channel 0 inclusive, otherwise strictly above the current channel
    adc_next_channel #(.NUM_CH(NUM_CH)) u_next (
        .mask            (state == IDLE ? ChannelMask : mask_q),
        .current         (state == IDLE ? 2'd0 : cur_ch),
        .include_current (state == IDLE),
        .found           (nxt_found),
        .next_ch         (nxt_ch)
    );

    // a zero settle count still spends one cycle in SETTLE
    assign settle_end  = {1'b0, tmr} + 9'd1 >= {1'b0, settle_q};
    assign drain_end   = {1'b0, tmr} + 9'd1 >= 9'(DRAIN_CYC);
    assign last_sample = cnt + 8'd1 == samples_q;

    // scan state machine with registered outputs; abort overrides every transition
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            mask_q      <= '0;
            settle_q    <= '0;
            samples_q   <= '0;
            cur_ch      <= '0;
            tmr         <= '0;
            cnt         <= '0;
            MuxSel      <= '0;
            AdcStart    <= 1'b0;
            OutData     <= '0;
            OutData_en  <= 1'b0;
            ScanBusy    <= 1'b0;
            ScanDone    <= 1'b0;
            OverflowErr <= 1'b0;
        end else begin
            ScanDone   <= 1'b0;
            OutData_en <= 1'b0;
            if (ScanAbort) begin
                state    <= IDLE;
                AdcStart <= 1'b0;
                ScanBusy <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (ScanStart) begin
                        mask_q      <= ChannelMask;
                        settle_q    <= SettleCycles;
                        samples_q   <= SamplesPerCh;
                        OverflowErr <= 1'b0;
                        ScanBusy    <= 1'b1;
                        cur_ch      <= nxt_ch;
                        state       <= nxt_found ? SELECT : DONE;
                    end
                    SELECT: begin
                        MuxSel <= cur_ch;
                        tmr    <= '0;
                        state  <= SETTLE;
                    end
                    SETTLE: if (settle_end) begin
                        cnt      <= '0;
                        AdcStart <= samples_q != 8'd0;
                        state    <= samples_q == 8'd0 ? NEXT : ACQ;
                    end else begin
                        tmr <= tmr + 8'd1;
                    end
                    ACQ: if (AdcData_en) begin
                        cnt        <= cnt + 8'd1;
                        OutData_en <= !FifoFull;
                        if (FifoFull)
                            OverflowErr <= 1'b1;
                        else
                            OutData <= pack_word(cnt == 8'd0, cur_ch, ADC_OTR, AdcData);
                        if (last_sample) begin
                            AdcStart <= 1'b0;
                            tmr      <= '0;
                            state    <= DRAIN;
                        end
                    end
                    DRAIN: if (drain_end) state <= NEXT; else tmr <= tmr + 8'd1;
                    NEXT: begin
                        if (nxt_found) cur_ch <= nxt_ch;
                        state <= nxt_found ? SELECT : DONE;
                    end
                    DONE: begin
                        ScanDone <= 1'b1;
                        ScanBusy <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
